// File: rtl/load_use_hazard_unit_pkg.sv
// Shared pipeline definitions for the load-use hazard detector:
// register-address width, the $zero register, and the control-output bundle.
package load_use_hazard_unit_pkg;

    localparam int NB_REG = 5;
    localparam logic [NB_REG-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic write_if_id;
        logic mux_control;
        logic stall;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, write_if_id: 1'b1, mux_control: 1'b0, stall: 1'b0};
    localparam hazard_ctrl_t CTRL_STALL = '{pc_write: 1'b0, write_if_id: 1'b0, mux_control: 1'b1, stall: 1'b1};

endpackage

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector in ID: freezes PC and IF/ID and injects a bubble into
// ID/EX when the load in ID/EX writes a register read by the instruction in IF/ID.
module load_use_hazard_unit #(
    parameter int NB_REG   = load_use_hazard_unit_pkg::NB_REG,
    parameter int NB_COUNT = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                is_ID_EX_MemRead,
    input  logic [NB_REG-1:0]   i_ID_EX_Rt,
    input  logic [NB_REG-1:0]   i_IF_ID_Rs,
    input  logic [NB_REG-1:0]   i_IF_ID_Rt,
    output logic                o_PC_write,
    output logic                os_write_IF_ID,
    output logic                os_mux_control,
    output logic                o_stall,
    output logic [NB_COUNT-1:0] o_stall_count
);
    import load_use_hazard_unit_pkg::*;

    localparam logic [NB_COUNT-1:0] COUNT_MAX = '1;
    localparam logic [NB_COUNT-1:0] COUNT_ONE = NB_COUNT'(1);

    // rs and rt are both compared for every format; an I-type false stall is harmless.
    function automatic logic load_use_match(
        input logic              mem_read,
        input logic [NB_REG-1:0] ex_rt,
        input logic [NB_REG-1:0] id_rs,
        input logic [NB_REG-1:0] id_rt
    );
        return mem_read && (ex_rt != NB_REG'(ZERO_REG)) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

    logic                w_hazard;
    hazard_ctrl_t        w_ctrl;
    logic [NB_COUNT-1:0] r_stall_count;

    assign w_hazard = load_use_match(is_ID_EX_MemRead, i_ID_EX_Rt, i_IF_ID_Rs, i_IF_ID_Rt);

    // Zero-latency control steering; reset forces the free-running values.
    always_comb begin
        w_ctrl = CTRL_RUN;
        if (!i_rst_n) begin
            w_ctrl = CTRL_RUN;
        end else if (w_hazard) begin
            w_ctrl = CTRL_STALL;
        end else begin
            w_ctrl = CTRL_RUN;
        end
    end

    // Saturating count of bubbles inserted while the pipeline is advancing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= '0;
        end else if (i_enable && w_hazard && (r_stall_count != COUNT_MAX)) begin
            r_stall_count <= r_stall_count + COUNT_ONE;
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign o_PC_write     = w_ctrl.pc_write;
    assign os_write_IF_ID = w_ctrl.write_if_id;
    assign os_mux_control = w_ctrl.mux_control;
    assign o_stall        = w_ctrl.stall;
    assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Scoreboard bench for load_use_hazard_unit: a 32-bit instance plus a 3-bit-counter
// instance on the same inputs so that saturation is reachable.
module tb_load_use_hazard_unit;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] cnt;
        logic [2:0]  sat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        mem_read;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;

    logic        pc_write, write_ifid, mux_ctrl, stall;
    logic [31:0] stall_count;
    logic        s_pc_write, s_write_ifid, s_mux_ctrl, s_stall;
    logic [2:0]  s_stall_count;
    logic [3:0]  obs_ctrl;

    exp_t        sb[$];
    exp_t        ent;
    logic [31:0] exp_count;
    logic [2:0]  exp_sat;
    int          total;
    int          bad;

    assign obs_ctrl = {pc_write, write_ifid, mux_ctrl, stall};

    load_use_hazard_unit #(.NB_REG(5), .NB_COUNT(32)) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_enable         (enable),
        .is_ID_EX_MemRead (mem_read),
        .i_ID_EX_Rt       (ex_rt),
        .i_IF_ID_Rs       (id_rs),
        .i_IF_ID_Rt       (id_rt),
        .o_PC_write       (pc_write),
        .os_write_IF_ID   (write_ifid),
        .os_mux_control   (mux_ctrl),
        .o_stall          (stall),
        .o_stall_count    (stall_count)
    );

    load_use_hazard_unit #(.NB_REG(5), .NB_COUNT(3)) u_sat (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_enable         (enable),
        .is_ID_EX_MemRead (mem_read),
        .i_ID_EX_Rt       (ex_rt),
        .i_IF_ID_Rs       (id_rs),
        .i_IF_ID_Rt       (id_rt),
        .o_PC_write       (s_pc_write),
        .os_write_IF_ID   (s_write_ifid),
        .os_mux_control   (s_mux_ctrl),
        .o_stall          (s_stall),
        .o_stall_count    (s_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic model_hz(input logic mr, input logic [4:0] e, input logic [4:0] s, input logic [4:0] t);
        return mr && (e != 5'd0) && ((e == s) || (e == t));
    endfunction

    // Drive one cycle of stimulus at the falling edge and push its expected outputs.
    task automatic drive(input logic r, input logic mr, input logic [4:0] e,
                         input logic [4:0] s, input logic [4:0] t, input logic en);
        @(negedge clk);
        rst_n    = r;
        mem_read = mr;
        ex_rt    = e;
        id_rs    = s;
        id_rt    = t;
        enable   = en;
        if (!r) begin
            exp_count = 32'd0;
            exp_sat   = 3'd0;
        end
        ent.ctrl = (r && model_hz(mr, e, s, t)) ? 4'b0011 : 4'b1100;
        ent.cnt  = exp_count;
        ent.sat  = exp_sat;
        sb.push_back(ent);
    endtask

    // Advance through a rising edge and update the counter models.
    task automatic tick();
        @(posedge clk);
        if (rst_n && enable && model_hz(mem_read, ex_rt, id_rs, id_rt)) begin
            if (exp_count != 32'hFFFF_FFFF) exp_count = exp_count + 32'd1;
            if (exp_sat != 3'b111) exp_sat = exp_sat + 3'd1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive((i < 2) ? 1'b0 : 1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 1'b1);
            #1;
            if (sb.size() == 0) begin bad++; total++; $display("FAIL reset scoreboard empty"); end
            else begin
                ent = sb.pop_front();
                total += 3;
                if (obs_ctrl !== ent.ctrl) begin bad++; $display("FAIL reset_ctrl[%0d] got=%b exp=%b", i, obs_ctrl, ent.ctrl); end
                if (stall_count !== ent.cnt) begin bad++; $display("FAIL reset_count[%0d] got=%0d exp=%0d", i, stall_count, ent.cnt); end
                if (s_stall_count !== ent.sat) begin bad++; $display("FAIL reset_sat[%0d] got=%0d exp=%0d", i, s_stall_count, ent.sat); end
            end
            tick();
        end
    endtask

    task automatic test_rs_match();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd1, 5'd1, 5'd0, 1'b1);
            #1;
            ent = sb.pop_front();
            total += 3;
            if (obs_ctrl !== ent.ctrl) begin bad++; $display("FAIL rs_match_ctrl[%0d] got=%b exp=%b", i, obs_ctrl, ent.ctrl); end
            if (stall_count !== ent.cnt) begin bad++; $display("FAIL rs_match_count[%0d] got=%0d exp=%0d", i, stall_count, ent.cnt); end
            if (s_stall_count !== ent.sat) begin bad++; $display("FAIL rs_match_sat[%0d] got=%0d exp=%0d", i, s_stall_count, ent.sat); end
            tick();
        end
    endtask

    task automatic test_rt_and_miss();
        logic [4:0] rs_tab [4] = '{5'd2, 5'd2, 5'd3, 5'd3};
        logic [4:0] rt_tab [4] = '{5'd1, 5'd1, 5'd2, 5'd2};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd1, rs_tab[i], rt_tab[i], 1'b1);
            #1;
            ent = sb.pop_front();
            total += 3;
            if (obs_ctrl !== ent.ctrl) begin bad++; $display("FAIL rt_miss_ctrl[%0d] got=%b exp=%b", i, obs_ctrl, ent.ctrl); end
            if (stall_count !== ent.cnt) begin bad++; $display("FAIL rt_miss_count[%0d] got=%0d exp=%0d", i, stall_count, ent.cnt); end
            if (s_stall_count !== ent.sat) begin bad++; $display("FAIL rt_miss_sat[%0d] got=%0d exp=%0d", i, s_stall_count, ent.sat); end
            tick();
        end
    endtask

    task automatic test_no_stall_cases();
        logic       mr_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0] ex_tab [4] = '{5'd1, 5'd7, 5'd0, 5'd0};
        logic [4:0] rs_tab [4] = '{5'd1, 5'd9, 5'd0, 5'd4};
        logic [4:0] rt_tab [4] = '{5'd1, 5'd7, 5'd0, 5'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mr_tab[i], ex_tab[i], rs_tab[i], rt_tab[i], 1'b1);
            #1;
            ent = sb.pop_front();
            total += 3;
            if (obs_ctrl !== ent.ctrl) begin bad++; $display("FAIL no_stall_ctrl[%0d] got=%b exp=%b", i, obs_ctrl, ent.ctrl); end
            if (stall_count !== ent.cnt) begin bad++; $display("FAIL no_stall_count[%0d] got=%0d exp=%0d", i, stall_count, ent.cnt); end
            if (s_stall_count !== ent.sat) begin bad++; $display("FAIL no_stall_sat[%0d] got=%0d exp=%0d", i, s_stall_count, ent.sat); end
            tick();
        end
    endtask

    task automatic test_enable_low();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd6, 5'd6, 5'd2, (i == 3) ? 1'b1 : 1'b0);
            #1;
            ent = sb.pop_front();
            total += 3;
            if (obs_ctrl !== ent.ctrl) begin bad++; $display("FAIL enable_low_ctrl[%0d] got=%b exp=%b", i, obs_ctrl, ent.ctrl); end
            if (stall_count !== ent.cnt) begin bad++; $display("FAIL enable_low_count[%0d] got=%0d exp=%0d", i, stall_count, ent.cnt); end
            if (s_stall_count !== ent.sat) begin bad++; $display("FAIL enable_low_sat[%0d] got=%0d exp=%0d", i, s_stall_count, ent.sat); end
            tick();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 5'd5, 5'd9, 5'd5, 1'b1);
            #1;
            ent = sb.pop_front();
            total += 3;
            if (obs_ctrl !== ent.ctrl) begin bad++; $display("FAIL sat_ctrl[%0d] got=%b exp=%b", i, obs_ctrl, ent.ctrl); end
            if (stall_count !== ent.cnt) begin bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, stall_count, ent.cnt); end
            if (s_stall_count !== ent.sat) begin bad++; $display("FAIL sat_small[%0d] got=%0d exp=%0d", i, s_stall_count, ent.sat); end
            tick();
        end
        #1;
        total++;
        if (s_stall_count !== 3'b111) begin bad++; $display("FAIL sat_final got=%0d exp=7", s_stall_count); end
    endtask

    task automatic test_reset_mid();
        logic r_tab [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(r_tab[i], 1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
            #1;
            ent = sb.pop_front();
            total += 3;
            if (obs_ctrl !== ent.ctrl) begin bad++; $display("FAIL reset_mid_ctrl[%0d] got=%b exp=%b", i, obs_ctrl, ent.ctrl); end
            if (stall_count !== ent.cnt) begin bad++; $display("FAIL reset_mid_count[%0d] got=%0d exp=%0d", i, stall_count, ent.cnt); end
            if (s_stall_count !== ent.sat) begin bad++; $display("FAIL reset_mid_sat[%0d] got=%0d exp=%0d", i, s_stall_count, ent.sat); end
            tick();
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_count = 32'd0;
        exp_sat   = 3'd0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        mem_read  = 1'b0;
        ex_rt     = 5'd0;
        id_rs     = 5'd0;
        id_rt     = 5'd0;

        test_reset();
        test_rs_match();
        test_rt_and_miss();
        test_no_stall_cases();
        test_enable_low();
        test_saturation();
        test_reset_mid();

        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_use_hazard_unit.md
Name: load_use_hazard_unit

Overview:
- Load-use hazard detector for the 5-stage MIPS pipeline; sits in ID and compares the load in ID/EX against the source registers of the instruction in IF/ID.
- On a hazard it freezes PC and IF/ID for one cycle and steers the ID/EX control mux to inject a bubble (all-zero control).
- Keeps a registered stall counter for the debug unit.

Parameters:
- NB_REG, 5, register-address width.
- NB_COUNT, 32, stall-counter width.

Ports:
- i_clk  in  1  pipeline clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  pipeline advance enable from the debug unit; 0 = pipeline frozen.
- is_ID_EX_MemRead  in  1  instruction in ID/EX is a load.
- i_ID_EX_Rt  in  NB_REG  destination (rt) of the instruction in ID/EX.
- i_IF_ID_Rs  in  NB_REG  rs field of the instruction in IF/ID.
- i_IF_ID_Rt  in  NB_REG  rt field of the instruction in IF/ID.
- o_PC_write  out  1  1 = PC may update, 0 = hold PC.
- os_write_IF_ID  out  1  1 = IF/ID may load, 0 = hold IF/ID.
- os_mux_control  out  1  1 = select zero control into ID/EX (bubble), 0 = normal decode.
- o_stall  out  1  combinational hazard flag (equals os_mux_control).
- o_stall_count  out  NB_COUNT  number of bubbles inserted since reset.

Behaviour:
- Hazard is combinational: hazard = is_ID_EX_MemRead AND (i_ID_EX_Rt != 0) AND ((i_ID_EX_Rt == i_IF_ID_Rs) OR (i_ID_EX_Rt == i_IF_ID_Rt)).
- Loads whose rt is $zero never stall.
- When hazard = 1: o_PC_write = 0, os_write_IF_ID = 0, os_mux_control = 1, o_stall = 1.
- When hazard = 0: o_PC_write = 1, os_write_IF_ID = 1, os_mux_control = 0, o_stall = 0.
- All four control outputs are zero-latency from the inputs. No registers sit in the control path.
- A match with MemRead = 0 never stalls; those cases are covered by forwarding.
- Both the rs and rt comparisons are made regardless of instruction format. A false stall on I-type is accepted.
- The stall self-clears: the next cycle the bubble sits in ID/EX with MemRead = 0. The unit holds no state for this.
- While i_rst_n = 0, control outputs are forced to the no-stall values: PC_write = 1, write_IF_ID = 1, mux_control = 0, stall = 0. o_stall_count is cleared to 0 asynchronously.
- o_stall_count increments by 1 on each rising edge where i_rst_n = 1, i_enable = 1 and hazard = 1.
- With i_enable = 0, the counter holds, but the control outputs still reflect the inputs.
- The counter saturates at all-ones; it does not wrap.
- Reset released mid-stall: outputs follow the inputs from the first non-reset instant; counting starts at the next qualifying edge.
- No X propagation: all inputs are treated as known. Outputs are fully defined for every input combination.

Decomposition:
- Shared pipeline package holds NB_REG and the ZERO_REG constant (5'd0).
- A single module with no sub-modules.
- The comparator is a local function or assign; the counter is one always block with async reset.

Test Plan:
- Reset held low, MemRead = 1, Rt = Rs = 1 -> PC_write = 1, write_IF_ID = 1, mux = 0, count = 0. Release reset -> PC_write = 0, write_IF_ID = 0, mux = 1.
- MemRead = 1, ID_EX_Rt = 1, Rs = 1, IF_ID_Rt = 0 -> PC_write = 0, write_IF_ID = 0, mux = 1; the count increments by 1 per enabled clock.
- MemRead = 1, ID_EX_Rt = 1, Rs = 2, IF_ID_Rt = 1 -> stall (0, 0, 1).
- MemRead = 1, ID_EX_Rt = 1, Rs = 3, IF_ID_Rt = 2 -> no stall (1, 1, 0), count unchanged.
- MemRead = 0, ID_EX_Rt = 1, Rs = 1 -> no stall (1, 1, 0). Separately, MemRead = 1, ID_EX_Rt = 0, Rs = 0 -> no stall (1, 1, 0).
- Hazard held with i_enable = 0 for 3 clocks -> outputs (0, 0, 1), count frozen. Count preloaded near all-ones -> saturates at all-ones.
